l1_mem_responder: RTL and testbench



---
 rtl/mem_pkg.sv | 33 +++
 rtl/l1_sram_array.sv | 36 +++
 rtl/l1_mem_responder.sv | 116 +++++++++++
 tb/tb_l1_mem_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared L1 request/response types used by the IF/data arbiter and the memory responder.
// Also holds the responder state encoding and a saturating-increment helper.
package mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int MEM_BE_W   = 4;

    typedef struct packed {
        logic                  valid;
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
        logic [MEM_BE_W-1:0]   be;
    } mem_req_t;

    typedef struct packed {
        logic                  ready;
        logic [MEM_DATA_W-1:0] rdata;
        logic                  err;
    } mem_resp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/l1_sram_array.sv
// DEPTH_WORDS x 32 backing array: synchronous byte-enable write, registered read port.
// Only the read register is reset; array contents survive reset.
module l1_sram_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_idx,
    output logic [31:0]   o_rdata,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_idx,
    input  logic [3:0]    i_wr_be,
    input  logic [31:0]   i_wr_data
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_wr_be[b]) r_mem[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       r_rdata <= '0;
        else if (i_rd_en) r_rdata <= r_mem[i_rd_idx];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/l1_mem_responder.sv
// L1 request responder: FSM, abort comparator and error checks in front of l1_sram_array.
// Optional macro L1_RESP_STATS_EN adds saturating outcome counters (stat_rd/wr/abort/err).
//   state | meaning
//   IDLE  | waiting for req.valid; latches the request into r_req_q
//   WAIT  | wait-state down-counter running; live req compared at terminal count
//   RESP  | single response cycle (ready unless aborted); write commits on its edge
module l1_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  mem_req_t  req,
    output mem_resp_t resp
`ifdef L1_RESP_STATS_EN
   ,output logic [31:0] stat_rd,
    output logic [31:0] stat_wr,
    output logic [31:0] stat_abort,
    output logic [31:0] stat_err
`endif
);

    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    resp_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    mem_req_t         r_req_q;
    logic             r_abort;

    logic          w_to_resp;
    logic          w_err_q;
    logic          w_ok;
    logic [AW-1:0] w_rd_idx;
    logic [31:0]   w_rdata_q;

    // With zero wait states the read must use the live address, as req_q is loaded on the same edge.
    assign w_to_resp = (r_state == ST_IDLE && req.valid && WAIT_CYCLES == 0) ||
                       (r_state == ST_WAIT && r_cnt == '0);
    assign w_rd_idx  = (r_state == ST_IDLE) ? req.addr[AW+1:2] : r_req_q.addr[AW+1:2];
    assign w_err_q   = (r_req_q.addr[1:0] != 2'b00) ||
                       (r_req_q.addr[31:2] >= 30'(DEPTH_WORDS));
    assign w_ok      = (r_state == ST_RESP) && !r_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_req_q <= '0;
            r_abort <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req.valid) begin
                        r_req_q <= req;
                        r_abort <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            r_state <= ST_RESP;
                        end else begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_RESP;
                        r_abort <= (req != r_req_q);
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    l1_sram_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_sram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rd_en   (w_to_resp),
        .i_rd_idx  (w_rd_idx),
        .o_rdata   (w_rdata_q),
        .i_wr_en   (w_ok && !w_err_q && r_req_q.we),
        .i_wr_idx  (r_req_q.addr[AW+1:2]),
        .i_wr_be   (r_req_q.be),
        .i_wr_data (r_req_q.wdata)
    );

    assign resp.ready = w_ok;
    assign resp.err   = w_ok && w_err_q;
    assign resp.rdata = (w_ok && !w_err_q && !r_req_q.we) ? w_rdata_q : '0;

`ifdef L1_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_rd    <= '0;
            stat_wr    <= '0;
            stat_abort <= '0;
            stat_err   <= '0;
        end else if (r_state == ST_RESP) begin
            if (r_abort)          stat_abort <= sat_inc(stat_abort);
            else if (w_err_q)     stat_err   <= sat_inc(stat_err);
            else if (r_req_q.we)  stat_wr    <= sat_inc(stat_wr);
            else                  stat_rd    <= sat_inc(stat_rd);
        end
    end
`endif

endmodule

// File: tb/tb_l1_mem_responder.sv
// Directed bench for l1_mem_responder: one instance with 2 wait states, one with none.
// Expected responses are queued when a request is driven and popped when ready is seen.
module tb_l1_mem_responder;
    import mem_pkg::*;

    logic      clk;
    logic      rst_n;
    mem_req_t  req2, req0;
    mem_resp_t resp2, resp0;
`ifdef L1_RESP_STATS_EN
    logic [31:0] st2_rd, st2_wr, st2_abort, st2_err;
    logic [31:0] st0_rd, st0_wr, st0_abort, st0_err;
`endif

    int checks = 0;
    int errors = 0;
    mem_resp_t exp_q[$];

    l1_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req2),
        .resp  (resp2)
`ifdef L1_RESP_STATS_EN
       ,.stat_rd    (st2_rd),
        .stat_wr    (st2_wr),
        .stat_abort (st2_abort),
        .stat_err   (st2_err)
`endif
    );

    l1_mem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req0),
        .resp  (resp0)
`ifdef L1_RESP_STATS_EN
       ,.stat_rd    (st0_rd),
        .stat_wr    (st0_wr),
        .stat_abort (st0_abort),
        .stat_err   (st0_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic mem_resp_t cur_resp(input bit sel0);
        return sel0 ? resp0 : resp2;
    endfunction

    task automatic set_req(input bit sel0, input mem_req_t r);
        if (sel0) req0 = r;
        else      req2 = r;
    endtask

    function automatic mem_req_t mk_req(input logic we, input logic [31:0] a,
                                        input logic [31:0] d, input logic [3:0] be);
        mem_req_t r;
        r.valid = 1'b1;
        r.we    = we;
        r.addr  = a;
        r.wdata = d;
        r.be    = be;
        return r;
    endfunction

    task automatic push_exp(input logic err, input logic [31:0] rd);
        mem_resp_t e;
        e.ready = 1'b1;
        e.err   = err;
        e.rdata = rd;
        exp_q.push_back(e);
    endtask

    // n counts negedges from the IDLE cycle in which valid is sampled (n=0).
    task automatic wait_resp(input bit sel0, input string tag, input int exp_lat);
        int n;
        mem_resp_t e;
        n = 0;
        @(negedge clk);
        while (!cur_resp(sel0).ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_resp"}, {30'b0, cur_resp(sel0)}, {30'b0, e});
        end
    endtask

    task automatic run(input bit sel0, input logic we, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic exp_err, input logic [31:0] exp_rd,
                       input string tag);
        @(posedge clk); #1;
        set_req(sel0, mk_req(we, a, d, be));
        push_exp(exp_err, exp_rd);
        wait_resp(sel0, tag, sel0 ? 1 : 3);
        @(posedge clk); #1;
        set_req(sel0, '0);
    endtask

    task automatic abort_by_drop(input logic [31:0] a);
        @(posedge clk); #1;
        req2 = mk_req(1'b0, a, 32'h0, 4'h0);
        @(posedge clk); #1;
        req2 = '0;
        repeat (3) @(negedge clk);
        chk("drop_abort_ready", {30'b0, resp2}, 64'h0);
    endtask

    initial begin
        logic [31:0] b2b_addr [8];
        int n, k, last;
        mem_resp_t e;

        rst_n = 1'b0;
        req2  = '0;
        req0  = '0;
        repeat (3) @(negedge clk);
        chk("reset_resp2", {30'b0, resp2}, 64'h0);
        chk("reset_resp0", {30'b0, resp0}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_resp2", {30'b0, resp2}, 64'h0);

        run(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, "wr_10");
        run(0, 1'b0, 32'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF, "rd_10");

        run(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0, "wr_20_full");
        run(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0, "wr_20_be");
        run(0, 1'b0, 32'h20, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, "rd_20_be");
        run(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0, "wr_20_be0");
        run(0, 1'b0, 32'h20, 32'h0,        4'h0, 1'b0, 32'h11BB33DD, "rd_20_be0");

        run(0, 1'b1, 32'h0,    32'hCAFE0000, 4'hF, 1'b0, 32'h0, "wr_0");
        run(0, 1'b0, 32'h22,   32'h0,        4'h0, 1'b1, 32'h0, "rd_misalign");
        run(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, 1'b1, 32'h0, "wr_oob");
        run(0, 1'b0, 32'h1000, 32'h0,        4'h0, 1'b1, 32'h0, "rd_oob");
        run(0, 1'b0, 32'h0,    32'h0,        4'h0, 1'b0, 32'hCAFE0000, "rd_0_after_oob");

        // IF read of 0x40 pre-empted during WAIT by a data write to 0x80
        run(0, 1'b1, 32'h40, 32'h40404040, 4'hF, 1'b0, 32'h0, "wr_40");
        run(0, 1'b1, 32'h80, 32'h0,        4'hF, 1'b0, 32'h0, "wr_80_clr");
        @(posedge clk); #1;
        req2 = mk_req(1'b0, 32'h40, 32'h0, 4'h0);
        @(posedge clk); #1;
        req2 = mk_req(1'b1, 32'h80, 32'h80808080, 4'hF);
        push_exp(1'b0, 32'h0);
        repeat (3) @(negedge clk);
        chk("preempt_abort_ready", {30'b0, resp2}, 64'h0);
        wait_resp(0, "preempt_wr_80", 3);
        @(posedge clk); #1;
        req2 = '0;
        run(0, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 32'h40404040, "rd_40_after_abort");
        run(0, 1'b0, 32'h80, 32'h0, 4'h0, 1'b0, 32'h80808080, "rd_80_after_abort");

        // reset asserted in the WAIT of a write to 0x30
        run(0, 1'b1, 32'h30, 32'h30303030, 4'hF, 1'b0, 32'h0, "wr_30");
        @(posedge clk); #1;
        req2 = mk_req(1'b1, 32'h30, 32'hBADBAD00, 4'hF);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wait_resp", {30'b0, resp2}, 64'h0);
        req2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_held_resp", {30'b0, resp2}, 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h30303030, "rd_30_after_rst");

        // zero wait states: preload, then 8 back-to-back reads with valid held high
        for (int i = 0; i < 8; i++) begin
            b2b_addr[i] = 32'h100 + 32'(i * 4);
            run(1, 1'b1, b2b_addr[i], 32'hB0000000 + 32'(i), 4'hF, 1'b0, 32'h0, "w0_wr");
        end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) push_exp(1'b0, 32'hB0000000 + 32'(i));
        req0 = mk_req(1'b0, b2b_addr[0], 32'h0, 4'h0);
        n = 0;
        k = 0;
        last = -1;
        @(negedge clk);
        while (k < 8 && n < 40) begin
            @(negedge clk);
            n++;
            if (resp0.ready) begin
                e = exp_q.pop_front();
                chk("b2b_resp", {30'b0, resp0}, {30'b0, e});
                last = n;
                k++;
                @(posedge clk); #1;
                if (k < 8) req0.addr = b2b_addr[k];
                else       req0 = '0;
            end
        end
        chk("b2b_count", 64'(k), 64'd8);
        chk("b2b_last_cycle", 64'(last), 64'd15);

`ifdef L1_RESP_STATS_EN
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("stat_rd_reset", 64'(st2_rd), 64'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, "st_rd_a");
        run(0, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h30303030, "st_rd_b");
        run(0, 1'b1, 32'h50, 32'h55555555, 4'hF, 1'b0, 32'h0, "st_wr_a");
        run(0, 1'b0, 32'h50, 32'h0, 4'h0, 1'b0, 32'h55555555, "st_rd_c");
        run(0, 1'b1, 32'h54, 32'h66666666, 4'h3, 1'b0, 32'h0, "st_wr_b");
        abort_by_drop(32'h10);
        run(0, 1'b0, 32'h22, 32'h0, 4'h0, 1'b1, 32'h0, "st_err");
        @(negedge clk);
        chk("stat_rd",    64'(st2_rd),    64'd3);
        chk("stat_wr",    64'(st2_wr),    64'd2);
        chk("stat_abort", 64'(st2_abort), 64'd1);
        chk("stat_err",   64'(st2_err),   64'd1);
`else
        abort_by_drop(32'h10);
        run(0, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, 32'hDEADBEEF, "rd_after_drop");
`endif

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
